// File: rtl/fwd_hazard_scoreboard_if.sv
// fwd_hazard_scoreboard_if: forwarding/hazard bundle between pipeline control and the scoreboard
interface fwd_hazard_scoreboard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W = 16
);
  logic [NUM_SRC*REG_ADDR_W-1:0] ex_rs_i;
  logic mem_regwrite_i;
  logic [REG_ADDR_W-1:0] mem_rd_i;
  logic wb_regwrite_i;
  logic [REG_ADDR_W-1:0] wb_rd_i;
  logic [NUM_SRC*2-1:0] fwd_sel_o;
  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs_i;
  logic [NUM_SRC-1:0] id_use_i;
  logic issue_i;
  logic [REG_ADDR_W-1:0] issue_rd_i;
  logic complete_i;
  logic [REG_ADDR_W-1:0] complete_rd_i;
  logic stall_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic deadlock_o;
  logic proto_err_o;
  modport slave (
    input ex_rs_i, mem_regwrite_i, mem_rd_i, wb_regwrite_i, wb_rd_i, id_rs_i, id_use_i,
          issue_i, issue_rd_i, complete_i, complete_rd_i,
    output fwd_sel_o, stall_o, stall_cnt_o, deadlock_o, proto_err_o
  );
  modport master (
    output ex_rs_i, mem_regwrite_i, mem_rd_i, wb_regwrite_i, wb_rd_i, id_rs_i, id_use_i,
           issue_i, issue_rd_i, complete_i, complete_rd_i,
    input fwd_sel_o, stall_o, stall_cnt_o, deadlock_o, proto_err_o
  );
endinterface

// File: rtl/fwd_hazard_scoreboard.sv
// fwd_hazard_scoreboard: EX operand forwarding plus long-latency scoreboard driving ID stalls
module fwd_hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W = 16,
  parameter int STALL_TIMEOUT = 64
) (
  input logic clk_i,
  input logic rst_i,
  fwd_hazard_scoreboard_if.slave bus
);
  localparam int NUM_REGS = 2**REG_ADDR_W;
  localparam int RUN_W = $clog2(STALL_TIMEOUT+1);
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic deadlock_q, deadlock_d, perr_q, perr_d;
  logic stall, issue_fire, bad_cmp;
  logic [NUM_SRC*2-1:0] fwd;
  always_comb begin
    fwd = '0;
    stall = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      fwd[2*k +: 2] = (bus.mem_regwrite_i && bus.mem_rd_i != '0 &&
                       bus.mem_rd_i == bus.ex_rs_i[k*REG_ADDR_W +: REG_ADDR_W]) ? 2'b10 :
                      (bus.wb_regwrite_i && bus.wb_rd_i != '0 &&
                       bus.wb_rd_i == bus.ex_rs_i[k*REG_ADDR_W +: REG_ADDR_W]) ? 2'b01 : 2'b00;
      stall = stall | (bus.id_use_i[k] && bus.id_rs_i[k*REG_ADDR_W +: REG_ADDR_W] != '0 &&
                       pending_q[bus.id_rs_i[k*REG_ADDR_W +: REG_ADDR_W]] &&
                       !(bus.complete_i && bus.complete_rd_i == bus.id_rs_i[k*REG_ADDR_W +: REG_ADDR_W]));
    end
  end
  always_comb begin
    issue_fire = bus.issue_i && !stall && bus.issue_rd_i != '0;
    bad_cmp = bus.complete_i && bus.complete_rd_i != '0 && !pending_q[bus.complete_rd_i] &&
              !(issue_fire && bus.issue_rd_i == bus.complete_rd_i);
    pending_d = pending_q;
    if (bus.complete_i && bus.complete_rd_i != '0) pending_d[bus.complete_rd_i] = 1'b0;
    if (issue_fire) pending_d[bus.issue_rd_i] = 1'b1;
    pending_d[0] = 1'b0;
    cnt_d = cnt_q + CNT_W'(stall && cnt_q != '1);
    run_d = !stall ? '0 : run_q + RUN_W'(run_q != RUN_W'(STALL_TIMEOUT));
    deadlock_d = deadlock_q | (run_d == RUN_W'(STALL_TIMEOUT));
    perr_d = perr_q | bad_cmp;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= '0;
      cnt_q <= '0;
      run_q <= '0;
      deadlock_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      deadlock_q <= deadlock_d;
      perr_q <= perr_d;
    end
  end
  assign bus.fwd_sel_o = fwd;
  assign bus.stall_o = stall;
  assign bus.stall_cnt_o = cnt_q;
  assign bus.deadlock_o = deadlock_q;
  assign bus.proto_err_o = perr_q;
endmodule
